// File: rtl/gate_checker_pkg.sv
// Shared definitions for the gate checker:
// FSM state encodings, vector count and counter widths.
package gate_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

endpackage

// File: rtl/gate_checker_settle_timer.sv
// Settle down-counter: loads a start value, counts
// down to zero and holds there, flagging zero.
module settle_timer
    import gate_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load on request, otherwise count down and stop at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_checker.sv
// Truth-table sweeper for a 2-input gate under test:
// applies all four input vectors and scores the responses.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] tt_exp,
    input  logic       dut_out,
    output logic       din_a,
    output logic       din_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_map
);

    // SETTLE spans SETTLE_CYC cycles: counter walks N-1..0
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_tt;
    logic [1:0]       r_din;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_err;
    logic [3:0]       r_fail;

    logic             w_load;
    logic             w_zero;
    logic             w_mis;
    logic             w_last;

    assign w_load = (r_state == APPLY);
    assign w_mis  = dut_out ^ r_tt[r_idx];
    assign w_last = (r_idx == LAST_IDX);

    settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .o_zero     (w_zero)
    );

    // Sweep FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_tt    <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tt    <= tt_exp;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                        r_din   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    r_state <= (SETTLE_CYC == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (w_zero) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_mis) begin
                        r_fail[r_idx] <= 1'b1;
                        r_err         <= r_err + 3'd1;
                    end
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == '0) && !w_mis;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_din   <= r_idx + IDX_W'(1);
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign din_a    = r_din[1];
    assign din_b    = r_din[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign fail_map = r_fail;

endmodule
